// File: rtl/audio_level_sequencer.sv
// audio_level_sequencer: windowed peak meter draining the audio-in FIFO into a 0-9 level.
// Define AUDIO_LEVEL_DECAY_EN for peak-hold ballistics (level falls one step per window).
module audio_level_sequencer #(
  parameter int WINDOW_SAMPLES = 48000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  output logic        read_audio_in,
  output logic [3:0]  level,
  output logic        level_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WAIT, POP, ACCUM, PUBLISH} state_t;
  localparam logic [19:0] WIN = 20'(WINDOW_SAMPLES);
  state_t state, state_nx;
  logic [31:0] sample, peak, mag;
  logic [19:0] count;
  logic [3:0] lvl, level_nx, level_r;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? WAIT : IDLE;
      WAIT:    state_nx = !enable ? IDLE : audio_in_available ? POP : WAIT;
      POP:     state_nx = ACCUM;
      ACCUM:   state_nx = (count + 20'd1 == WIN) ? PUBLISH : WAIT;
      PUBLISH: state_nx = enable ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    mag = !sample[31] ? sample : (sample == 32'h8000_0000) ? 32'h7fff_ffff : -sample;
    lvl = '0;
    for (int k = 1; k <= 9; k++) lvl = lvl + 4'(peak >= (32'd1 << (12 + 2 * k)));
`ifdef AUDIO_LEVEL_DECAY_EN
    level_nx = (lvl >= level_r) ? lvl : level_r - 4'd1;
`else
    level_nx = lvl;
`endif
  end
  // level is shown during the strobe cycle itself, then held in level_r
  assign read_audio_in = state == POP;
  assign level_valid   = state == PUBLISH;
  assign busy          = (state == WAIT && count != '0) || state == POP || state == ACCUM;
  assign level         = level_valid ? level_nx : level_r;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      sample  <= '0;
      peak    <= '0;
      count   <= '0;
      level_r <= '0;
    end else begin
      state <= state_nx;
      if (state == POP) sample <= left_channel_audio_in;
      if (state == ACCUM) begin
        peak  <= (mag > peak) ? mag : peak;
        count <= count + 20'd1;
      end
      if (state == IDLE || state == PUBLISH) begin
        peak  <= '0;
        count <= '0;
      end
      if (state == PUBLISH) level_r <= level_nx;
    end
endmodule

// File: tb/tb_audio_level_sequencer.sv
// tb_audio_level_sequencer: directed checks of the level sequencer with a 4-sample window.
module tb_audio_level_sequencer;
`ifdef AUDIO_LEVEL_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif
  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic gate = 1'b1;
  logic rand_mode = 1'b0;
  logic audio_in_available, read_audio_in, level_valid, busy;
  logic [31:0] left_channel_audio_in;
  logic [3:0] level;
  logic [31:0] mem [128];
  int rd_idx = 0, wr_idx = 0;
  int pops = 0, valids = 0, viol = 0, dbl = 0;
  int n_chk = 0, n_err = 0;
  logic avail_prev = 1'b0, read_prev = 1'b0;
  logic [3:0] exp_lvl = '0;

  audio_level_sequencer #(.WINDOW_SAMPLES(4)) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .enable(enable),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in),
    .read_audio_in(read_audio_in),
    .level(level),
    .level_valid(level_valid),
    .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign audio_in_available = gate && (rd_idx < wr_idx);
  assign left_channel_audio_in = mem[rd_idx];

  always @(negedge CLOCK_50) gate <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge CLOCK_50) begin
    if (read_audio_in) begin
      pops++;
      if (!avail_prev) viol++;
      if (read_prev) dbl++;
      rd_idx <= rd_idx + 1;
    end
    if (level_valid) valids++;
    avail_prev = audio_in_available;
    read_prev = read_audio_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_idx] = v;
    wr_idx++;
  endtask

  function automatic logic [3:0] model(input logic [3:0] l, input logic [3:0] prev);
    return (!DECAY || l >= prev) ? l : prev - 4'd1;
  endfunction

  task automatic wait_valid(input int lim, output int cyc);
    cyc = 0;
    while (!level_valid && cyc < lim) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check("valid_seen", level_valid, 1);
  endtask

  task automatic run_window(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input logic [3:0] l,
                            input int lim);
    int p0, cyc;
    p0 = pops;
    push(a); push(b); push(c); push(d);
    wait_valid(lim, cyc);
    exp_lvl = model(l, exp_lvl);
    check({tag, "_lvl"}, level, exp_lvl);
    check({tag, "_pops"}, pops - p0, 4);
    @(negedge CLOCK_50);
    check({tag, "_strobe"}, level_valid, 0);
    check({tag, "_hold"}, level, exp_lvl);
  endtask

  initial begin
    int cyc, p0, v0, n;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    push(32'd100); push(-32'sd70000); push(32'd5); push(32'h8000_0000);
    enable = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_read", read_audio_in, 0);
    check("rst_level", level, 0);
    check("rst_valid", level_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pops", pops, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    check("c1_read", read_audio_in, 0);
    @(negedge CLOCK_50);
    check("c2_read", read_audio_in, 1);
    check("c2_busy", busy, 1);
    wait_valid(40, cyc);
    check("w1_latency", cyc, 11);
    exp_lvl = model(4'd9, exp_lvl);
    check("w1_lvl", level, exp_lvl);
    check("w1_pops", pops, 4);
    @(negedge CLOCK_50);
    check("w1_strobe", level_valid, 0);
    check("w1_idle_busy", busy, 0);
    check("w1_hold", level, exp_lvl);

    run_window("w2", -32'sd20000, 32'd3, 32'd0, 32'd0, 4'd1, 100);
    run_window("w3", 32'h0010_0000, 32'h000f_ffff, 32'd0, 32'd0, 4'd4, 100);
    run_window("w4", 32'h4000_0000, 32'd0, 32'd0, 32'd0, 4'd9, 100);
    run_window("w5", 32'd100, 32'd100, 32'd100, 32'd100, 4'd0, 100);
    run_window("w6", 32'd100, 32'd100, 32'd100, 32'd100, 4'd0, 100);
    run_window("w7", 32'd16383, -32'sd16383, 32'd0, 32'hffff_ffff, 4'd0, 100);
    run_window("w8", 32'd16384, 32'd0, 32'd0, 32'd0, 4'd1, 100);
    run_window("w9", 32'h3fff_ffff, 32'd0, 32'd0, 32'd0, 4'd8, 100);
    run_window("w10", 32'd0, 32'hc000_0000, 32'd0, 32'd0, 4'd9, 100);

    rand_mode = 1'b1;
    p0 = pops;
    v0 = valids;
    run_window("r1", 32'h0001_0000, 32'd0, 32'd0, 32'd0, 4'd2, 300);
    run_window("r2", 32'd7, 32'd0, 32'd0, 32'd0, 4'd0, 300);
    rand_mode = 1'b0;
    check("rnd_pops", pops - p0, 8);
    check("rnd_valids", valids - v0, (pops - p0) / 4);
    check("rnd_viol", viol, 0);

    p0 = pops;
    v0 = valids;
    push(32'h4000_0000); push(32'h4000_0000);
    n = 0;
    while (pops < p0 + 2 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("drop_pops", pops - p0, 2);
    check("drop_busy_mid", busy, 1);
    enable = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("drop_busy_idle", busy, 0);
    check("drop_no_valid", valids - v0, 0);
    enable = 1'b1;
    run_window("drop_rerun", 32'd100, 32'd100, 32'd100, 32'd100, 4'd0, 100);

    v0 = valids;
    push(32'h4000_0000); push(32'h4000_0000); push(32'h4000_0000); push(32'h4000_0000);
    repeat (4) @(negedge CLOCK_50);
    check("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read", read_audio_in, 0);
    check("mid_rst_valid", level_valid, 0);
    check("mid_rst_level", level, 0);
    enable = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("mid_no_valid", valids - v0, 0);
    check("mid_level", level, 0);
    check("one_cycle_pops", dbl, 0);
    check("pop_viol", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
